frame_fetch: RTL
================

Name: frame_fetch

Overview:
- Read-side counterpart to the camera write path. Streams one stored frame out of the SDRAM frame buffer as 128-bit words, in the 133 MHz memory domain.
- Issues single-word read requests to the RAM controller and tracks outstanding reads with credits.
- Buffers returned words in an internal synchronous FIFO and presents them to the HDR/display consumer over a valid/ready interface.

Parameters:
- ADDR_W, 25, RAM word-address width
- DATA_W, 128, RAM data word width
- WORDS_PER_FRAME, 38400, words per frame (640x480x16bit/128)
- FRAME_STRIDE, 65536, address distance between frame slots; must be >= WORDS_PER_FRAME
- FIFO_DEPTH, 16, output FIFO depth (power of two)
- MAX_OUTSTANDING, 4, maximum accepted-but-unreturned reads

Ports:
- clk_133M  in  1  memory-domain clock
- rst_133M  in  1  reset; synchronous, active-high
- start  in  1  one-cycle pulse; begin fetching a frame
- frame_sel  in  3  frame slot index, sampled with start
- ram_busy  in  1  RAM controller cannot accept a request this cycle
- rd_req  out  1  read request; accepted on a cycle with rd_req && ~ram_busy
- rd_address  out  ADDR_W  word address of the pending request
- rd_data  in  DATA_W  returned read data
- rd_data_valid  in  1  rd_data valid; exactly one per accepted request, in order
- o_data  out  DATA_W  FIFO head word
- o_valid  out  1  o_data valid
- o_ready  in  1  consumer accepts o_data this cycle
- busy  out  1  frame fetch in progress (state != IDLE)
- frame_done  out  1  one-cycle pulse when the frame is fully delivered
- err_unexpected  out  1  sticky; rd_data_valid seen with zero outstanding

Behaviour:
- Reset values: rd_req=0, rd_address=0, o_valid=0, o_data=0, busy=0, frame_done=0, err_unexpected=0. Counters zero, FIFO empty, state IDLE.
- Reset mid-frame aborts the fetch immediately. Responses arriving after reset find zero outstanding and set err_unexpected. The system resets the RAM controller together with this block.
- FSM:
  - IDLE: on start, latch base = frame_sel*FRAME_STRIDE, clear req_cnt, go to FETCH. start is ignored in any other state.
  - FETCH: issue requests. When the request with req_cnt == WORDS_PER_FRAME-1 is accepted, go to DRAIN.
  - DRAIN: wait for outstanding==0 and the FIFO to be empty. Then pulse frame_done for one cycle, return to IDLE, busy=0.
- Request handshake:
  - rd_req and rd_address are registered. rd_address = base + req_cnt, truncated to ADDR_W.
  - Once rd_req is raised, rd_req and rd_address stay stable until accepted (rd_req && ~ram_busy).
  - After acceptance, rd_req drops in the next cycle unless a new request may issue. Back-to-back acceptance with address+1 is allowed.
  - First rd_req is asserted the cycle after start is sampled.
- Credit rule: a new request may be raised only if outstanding < MAX_OUTSTANDING and fifo_count + outstanding < FIFO_DEPTH. By construction the FIFO never overflows.
- outstanding bookkeeping:
  - +1 on acceptance, -1 on rd_data_valid; both in the same cycle leaves it unchanged.
  - rd_data_valid with outstanding==0: data discarded, err_unexpected set, counters unchanged.
- FIFO:
  - Written on every counted rd_data_valid.
  - Pop on o_valid && o_ready. With the FIFO empty, a word written in cycle N is visible on o_data/o_valid in cycle N+1.
  - Simultaneous push and pop keeps the count; push into a full FIFO is impossible by the credit rule.
  - o_valid low with o_ready high is harmless; o_data holds its last value when not valid.
- req_cnt width is clog2(WORDS_PER_FRAME)+1. The frame end is detected on the accept of the last word; req_cnt never wraps within a frame.

Decomposition:
- Package hdr_mem_pkg holds: ADDR_W, DATA_W, WORDS_PER_FRAME, FRAME_STRIDE, the frame_fetch state encoding (IDLE/FETCH/DRAIN), and a clog2 helper.
- One sub-module: sync_fifo. Parameters are width and depth. Signals: wr_en, rd_en, full, empty, count, and a registered head output. Shared with other single-clock buffers in the design.

Test Plan:
- Basic frame (WORDS_PER_FRAME=8 override, frame_sel=2, FRAME_STRIDE=16), ram_busy=0, 2-cycle read latency, o_ready=1 -> rd_address 32..39 in order; o_data matches the RAM model; one frame_done after the last pop; busy low afterwards.
- Stall: ram_busy high for 5 cycles while rd_req is pending at address 35 -> rd_req and rd_address stay at 35 throughout; exactly one accept; no duplicate or skipped address.
- Backpressure: o_ready=0 for the whole fetch, FIFO_DEPTH=4 -> at most 4 requests accepted; rd_req stays low after that. Raising o_ready drains the FIFO and resumes requests; all 8 words arrive in order.
- Outstanding cap: 10-cycle read latency, MAX_OUTSTANDING=4 -> never more than 4 accepts ahead of returns. Simultaneous accept and return keeps the count stable (checked by assertion).
- Spurious return: rd_data_valid pulse in IDLE -> err_unexpected=1 and stays set; FIFO remains empty; o_valid=0.
- Reset mid-FETCH after 3 accepts, then start with frame_sel=0 -> all outputs at reset values; the new fetch begins at address 0; frame_done fires once for the new frame only.

Source files
------------

// File: rtl/hdr_mem_pkg.sv
// Shared constants, frame_fetch state encoding and a clog2 helper for the HDR memory path.
package hdr_mem_pkg;

  localparam int unsigned ADDR_W          = 25;
  localparam int unsigned DATA_W          = 128;
  localparam int unsigned WORDS_PER_FRAME = 38400;
  localparam int unsigned FRAME_STRIDE    = 65536;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } ff_state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/frame_fetch_if.sv
// RAM read port plus output stream of the frame fetcher; master is the fetcher side.
interface frame_fetch_if;
  import hdr_mem_pkg::*;

  logic              rd_req;
  logic [ADDR_W-1:0] rd_address;
  logic              ram_busy;
  logic [DATA_W-1:0] rd_data;
  logic              rd_data_valid;
  logic [DATA_W-1:0] o_data;
  logic              o_valid;
  logic              o_ready;

  modport master (
    output rd_req, rd_address, o_data, o_valid,
    input  ram_busy, rd_data, rd_data_valid, o_ready
  );

  modport slave (
    input  rd_req, rd_address, o_data, o_valid,
    output ram_busy, rd_data, rd_data_valid, o_ready
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head word; head holds its last value once drained.
module sync_fifo import hdr_mem_pkg::*; #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [clog2(DEPTH):0]      count
);

  localparam int unsigned PTR_W = clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;

  assign empty = (count == CNT_W'(0));
  assign full  = (count == CNT_W'(DEPTH));
  assign pop   = rd_en && !empty;
  assign push  = wr_en && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Head tracks the oldest word: bypass on write into an empty (or emptying) FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (push) wr_ptr <= PTR_W'(wr_ptr + 1'b1);
      if (pop)  rd_ptr <= PTR_W'(rd_ptr + 1'b1);
      case ({push, pop})
        2'b10:   count <= CNT_W'(count + 1'b1);
        2'b01:   count <= CNT_W'(count - 1'b1);
        default: count <= count;
      endcase
      if (push && (empty || (pop && count == CNT_W'(1)))) begin
        head <= wr_data;
      end else if (pop && count > CNT_W'(1)) begin
        head <= mem[PTR_W'(rd_ptr + 1'b1)];
      end
    end
  end

endmodule

// File: rtl/frame_fetch.sv
// Streams one stored frame out of SDRAM: credit-limited single-word reads into an output FIFO.
module frame_fetch import hdr_mem_pkg::*; #(
  parameter int unsigned WORDS_PER_FRAME = hdr_mem_pkg::WORDS_PER_FRAME,
  parameter int unsigned FRAME_STRIDE    = hdr_mem_pkg::FRAME_STRIDE,
  parameter int unsigned FIFO_DEPTH      = 16,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                clk_133M,
  input  logic                rst_133M,
  input  logic                start,
  input  logic [2:0]          frame_sel,
  frame_fetch_if.master       bus,
  output logic                busy,
  output logic                frame_done,
  output logic                err_unexpected
);

  localparam int unsigned REQ_W  = clog2(WORDS_PER_FRAME) + 1;
  localparam int unsigned OUT_W  = clog2(MAX_OUTSTANDING) + 1;
  localparam int unsigned FCNT_W = clog2(FIFO_DEPTH) + 1;
  localparam int unsigned LVL_W  = clog2(FIFO_DEPTH + MAX_OUTSTANDING) + 1;

  ff_state_t         state;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] start_base;
  logic [REQ_W-1:0]  req_cnt;
  logic [REQ_W-1:0]  req_cnt_inc;
  logic [OUT_W-1:0]  outstanding;
  logic [OUT_W-1:0]  out_nxt;
  logic [LVL_W-1:0]  level_nxt;
  logic [FCNT_W-1:0] fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              accept;
  logic              counted;
  logic              pop;
  logic              credit_ok;

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk_133M),
    .rst     (rst_133M),
    .wr_en   (counted),
    .wr_data (bus.rd_data),
    .rd_en   (bus.o_ready),
    .head    (bus.o_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign bus.o_valid = !fifo_empty;

  // Credit check looks at next-cycle occupancy so a raised request can always land in the FIFO.
  always_comb begin
    accept      = bus.rd_req && !bus.ram_busy;
    counted     = bus.rd_data_valid && (outstanding != OUT_W'(0));
    pop         = bus.o_valid && bus.o_ready;
    out_nxt     = OUT_W'(outstanding + OUT_W'(accept) - OUT_W'(counted));
    level_nxt   = LVL_W'(LVL_W'(fifo_count) + LVL_W'(outstanding) + LVL_W'(accept) - LVL_W'(pop));
    credit_ok   = (out_nxt < OUT_W'(MAX_OUTSTANDING)) && (level_nxt < LVL_W'(FIFO_DEPTH));
    req_cnt_inc = REQ_W'(req_cnt + 1'b1);
    start_base  = ADDR_W'(32'(frame_sel) * FRAME_STRIDE);
  end

  always_ff @(posedge clk_133M) begin
    if (rst_133M) begin
      state          <= IDLE;
      base           <= '0;
      req_cnt        <= '0;
      outstanding    <= '0;
      bus.rd_req     <= 1'b0;
      bus.rd_address <= '0;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
      err_unexpected <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      outstanding <= out_nxt;
      if (bus.rd_data_valid && outstanding == OUT_W'(0)) err_unexpected <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            base           <= start_base;
            req_cnt        <= '0;
            bus.rd_req     <= 1'b1;
            bus.rd_address <= start_base;
            busy           <= 1'b1;
            state          <= FETCH;
          end
        end
        FETCH: begin
          if (accept) begin
            if (req_cnt == REQ_W'(WORDS_PER_FRAME - 1)) begin
              bus.rd_req <= 1'b0;
              state      <= DRAIN;
            end else begin
              req_cnt        <= req_cnt_inc;
              bus.rd_req     <= credit_ok;
              bus.rd_address <= ADDR_W'(base + ADDR_W'(req_cnt_inc));
            end
          end else if (!bus.rd_req) begin
            bus.rd_req     <= credit_ok;
            bus.rd_address <= ADDR_W'(base + ADDR_W'(req_cnt));
          end
        end
        DRAIN: begin
          if (outstanding == OUT_W'(0) && fifo_empty) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk_133M) disable iff (rst_133M)
    !(counted && fifo_full && !pop));

endmodule
